fetch_unit: RTL and testbench

- Instruction fetch stage, directly upstream of the single-port synchronous memory.
- Acts as the read-only bus master on the memory's bus.
  - Generates sequential word addresses from a PC.
  - Captures the memory's one-cycle-latency read data.
  - Buffers fetched instructions in a small FIFO and presents them to decode over a valid/ready handshake.
- Decode/execute redirect (branch/jump) flushes the stage and restarts fetch at a new PC.

---
 rtl/fetch_unit_if.sv | 35 +++
 rtl/fetch_unit.sv | 117 +++++++++++
 tb/tb_fetch_unit.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the fetch stage's memory bus, its decode-side
// valid/ready output and the redirect input.
//   master modport : fetch_unit side (drives bus_addr/we/wdata and the out_* beat)
//   slave modport  : environment side (memory + decode)
// Signals:
//   bus_addr/bus_we/bus_wdata : read address and (unused) write controls
//   bus_rdata                 : memory read data, one cycle after the address
//   out_valid/out_ready       : instruction handshake to decode
//   out_instr/out_pc          : head instruction and the address it came from
//   redir_valid/redir_pc      : single-cycle redirect request and target
interface fetch_unit_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] bus_addr;
   logic              bus_we;
   logic [DATA_W-1:0] bus_wdata;
   logic [DATA_W-1:0] bus_rdata;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_instr;
   logic [ADDR_W-1:0] out_pc;
   logic              redir_valid;
   logic [ADDR_W-1:0] redir_pc;

   modport master (
      output bus_addr, bus_we, bus_wdata, out_valid, out_instr, out_pc,
      input  bus_rdata, out_ready, redir_valid, redir_pc
   );

   modport slave (
      input  bus_addr, bus_we, bus_wdata, out_valid, out_instr, out_pc,
      output bus_rdata, out_ready, redir_valid, redir_pc
   );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Walks a word PC over a single-port
// synchronous memory (one-cycle read latency), buffers returned words in a
// DEPTH-entry FIFO and hands them to decode over valid/ready. A redirect
// flushes the FIFO, drops the in-flight read and restarts at redir_pc.
// Ports:
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset
//   bus          : fetch_unit_if.master (memory bus, decode handshake, redirect)
//   perf_bubbles : only when FETCH_PERF_CNT_EN is defined; saturating count of
//                  cycles where decode was ready but no instruction was valid
// Build option: define FETCH_PERF_CNT_EN to add the perf_bubbles counter.
module fetch_unit #(
   parameter int                ADDR_W   = 8,
   parameter int                DATA_W   = 32,
   parameter int                DEPTH    = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic         clk,
   input  logic         rst,
   fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]  perf_bubbles
`endif
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] reqpc_q;
   logic              req_q;

   logic [DATA_W-1:0] instr_q [DEPTH];
   logic [ADDR_W-1:0] ipc_q   [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;

   logic              pop;
   logic              push;
   logic              issue;
   logic [CNT_W:0]    credit;

   assign pop  = bus.out_valid & bus.out_ready & ~bus.redir_valid;
   assign push = req_q & ~bus.redir_valid;

   // Slots already committed (buffered + in flight) after this cycle's pop.
   // A new read is issued only if its data is guaranteed a free slot, so the
   // push side never needs back-pressure.
   assign credit = {1'b0, count} + (CNT_W+1)'(req_q) - (CNT_W+1)'(pop);
   assign issue  = ~bus.redir_valid & (credit < (CNT_W+1)'(DEPTH));

   assign bus.bus_addr  = pc_q;
   assign bus.bus_we    = 1'b0;
   assign bus.bus_wdata = '0;

   assign bus.out_valid = (count != '0);
   assign bus.out_instr = instr_q[rd_ptr];
   assign bus.out_pc    = ipc_q[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q    <= RESET_PC;
         reqpc_q <= '0;
         req_q   <= 1'b0;
      end else if (bus.redir_valid) begin
         pc_q  <= bus.redir_pc;
         req_q <= 1'b0;
      end else if (issue) begin
         req_q   <= 1'b1;
         reqpc_q <= pc_q;
         pc_q    <= pc_q + ADDR_W'(1);
      end else begin
         req_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            instr_q[i] <= '0;
            ipc_q[i]   <= '0;
         end
      end else if (bus.redir_valid) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            instr_q[wr_ptr] <= bus.bus_rdata;
            ipc_q[wr_ptr]   <= reqpc_q;
            wr_ptr          <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push && !pop) begin
            count <= count + CNT_W'(1);
         end else if (!push && pop) begin
            count <= count - CNT_W'(1);
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_bubbles <= '0;
      end else if (bus.out_ready && !bus.out_valid && (perf_bubbles != '1)) begin
         perf_bubbles <= perf_bubbles + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
   localparam int ADDR_W = 8;
   localparam int DATA_W = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_bubbles;
`endif

   fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(2), .RESET_PC(8'h00)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_bubbles(perf_bubbles)
`endif
   );

   // memory model: one-cycle read latency
   logic [31:0] mem [256];
   logic [31:0] rdata_q;
   initial for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
   always @(posedge clk) rdata_q <= mem[bus.bus_addr];
   assign bus.bus_rdata = rdata_q;

   int vectors = 0;
   int errs    = 0;
   int pops    = 0;

   // reference model: after reset or redirect to P the delivered pc stream
   // is P, P+1, P+2, ... (mod 256) and each instruction equals mem[pc]
   logic [7:0] exp_q [$];

   task automatic fill(input logic [7:0] p);
      exp_q.delete();
      for (int i = 0; i < 256; i++) exp_q.push_back(8'(p + i));
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // scoreboard monitor: compares every accepted beat against the model
   always @(negedge clk) begin
      if (rst === 1'b1 && bus.out_valid && bus.out_ready && !bus.redir_valid) begin
         vectors++;
         pops++;
         if (exp_q.size() == 0) begin
            errs++;
            $display("FAIL beat_unexpected: got pc %0h, expected no beat", bus.out_pc);
         end else begin
            logic [7:0] ep;
            ep = exp_q.pop_front();
            if (bus.out_pc !== ep || bus.out_instr !== mem[ep]) begin
               errs++;
               $display("FAIL beat: got pc %0h instr %0h, expected pc %0h instr %0h",
                        bus.out_pc, bus.out_instr, ep, mem[ep]);
            end
         end
      end
   end

   task automatic redirect(input logic [7:0] p);
      bus.redir_valid = 1'b1;
      bus.redir_pc    = p;
      fill(p);
   endtask

   initial begin
      logic [7:0] a0;
      int         p0;
      rst             = 1'b0;
      bus.out_ready   = 1'b0;
      bus.redir_valid = 1'b0;
      bus.redir_pc    = '0;
      fill(8'h00);
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 64'(bus.out_valid), 0);
      check("rst_instr", 64'(bus.out_instr), 0);
      check("rst_pc",    64'(bus.out_pc), 0);
      check("rst_addr",  64'(bus.bus_addr), 0);
      check("rst_we",    64'(bus.bus_we), 0);
      check("rst_wdata", 64'(bus.bus_wdata), 0);

      // reset release and first-beat latency
      bus.out_ready = 1'b1;
      rst = 1'b1;
      tick();
      check("lat_e1_valid", 64'(bus.out_valid), 0);
      check("lat_e1_addr",  64'(bus.bus_addr), 1);
      tick();
      check("lat_e2_valid", 64'(bus.out_valid), 1);
      check("lat_e2_pc",    64'(bus.out_pc), 0);
      check("lat_e2_instr", 64'(bus.out_instr), 64'h A000_0000);
`ifdef FETCH_PERF_CNT_EN
      check("perf_after_reset", 64'(perf_bubbles), 2);
`endif
      repeat (6) begin
         tick();
         check("stream_valid", 64'(bus.out_valid), 1);
      end

      // backpressure: exactly two buffered, fetch stalls
      bus.out_ready = 1'b0;
      repeat (3) tick();
      a0 = bus.bus_addr;
      repeat (3) tick();
      check("bp_addr_stable", 64'(bus.bus_addr), 64'(a0));
      check("bp_two_buffered", 64'(bus.bus_addr), 64'(8'(bus.out_pc + 8'd2)));
      check("bp_valid", 64'(bus.out_valid), 1);
      check("bp_we", 64'(bus.bus_we), 0);
      bus.out_ready = 1'b1;
      repeat (5) begin
         tick();
         check("bp_resume_valid", 64'(bus.out_valid), 1);
      end

      // redirect with FIFO full
      bus.out_ready = 1'b0;
      repeat (4) tick();
      redirect(8'h40);
      tick();
      bus.redir_valid = 1'b0;
      check("redir_e1_valid", 64'(bus.out_valid), 0);
      tick();
      check("redir_e2_valid", 64'(bus.out_valid), 0);
      tick();
      check("redir_e3_valid", 64'(bus.out_valid), 1);
      check("redir_e3_pc",    64'(bus.out_pc), 64'h40);
      check("redir_e3_instr", 64'(bus.out_instr), 64'(mem[8'h40]));
      bus.out_ready = 1'b1;
      repeat (4) tick();

      // redirect during a handshake, then a second one the next cycle
      check("b2b_pre_valid", 64'(bus.out_valid), 1);
      redirect(8'h10);
      tick();
      redirect(8'h80);
      tick();
      bus.redir_valid = 1'b0;
      tick();
      check("b2b_e1_valid", 64'(bus.out_valid), 0);
      tick();
      check("b2b_valid", 64'(bus.out_valid), 1);
      check("b2b_pc",    64'(bus.out_pc), 64'h80);
      repeat (3) tick();

      // PC wrap
      redirect(8'hFE);
      tick();
      bus.redir_valid = 1'b0;
      p0 = pops;
      repeat (8) tick();
      check("wrap_beats", 64'((pops - p0) >= 4), 1);

      // asynchronous reset mid-stream
      check("arst_pre_valid", 64'(bus.out_valid), 1);
      #2;
      rst = 1'b0;
      fill(8'h00);
      #1;
      check("arst_valid", 64'(bus.out_valid), 0);
      check("arst_addr",  64'(bus.bus_addr), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      tick();
      check("arst_e1_valid", 64'(bus.out_valid), 0);
      tick();
      check("arst_e2_valid", 64'(bus.out_valid), 1);
      check("arst_e2_pc",    64'(bus.out_pc), 0);
`ifdef FETCH_PERF_CNT_EN
      check("perf_after_arst", 64'(perf_bubbles), 2);
`endif

      // randomized traffic
      for (int c = 0; c < 400; c++) begin
         bus.out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 11) == 0) redirect(8'($urandom));
         else bus.redir_valid = 1'b0;
         tick();
      end
      bus.redir_valid = 1'b0;
      bus.out_ready   = 1'b1;
      repeat (10) tick();
      check("beats_total", 64'(pops >= 100), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
